// File: rtl/pwm_param_rx_pkg.sv
// Shared definitions for the PWM parameter frame receiver: frame layout,
// duty limit and FSM state encoding.
package pwm_param_rx_pkg;

  localparam int FRAME_LEN = 5;

  // word positions inside a parameter frame
  localparam int W_CH   = 0;
  localparam int W_FREQ = 1;
  localparam int W_DUTY = 2;
  localparam int W_RSV  = 3;
  localparam int W_EN   = 4;

  localparam int DUTY_MAX = 100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV_P,
    ST_MUL,
    ST_DIV_H,
    ST_OUT
  } state_e;

endpackage

// File: rtl/pwm_param_rx_div_serial.sv
// Serial restoring divider: one quotient bit per cycle, W steps per division.
// The first step happens in the cycle start is high, so done pulses W cycles
// after start with quotient/remainder valid; results hold until the next start.
module pwm_param_rx_div_serial #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [W-1:0]  op_rem, op_quo, op_dsr, diff;
  logic [W:0]    shl;

  // One restoring step on fresh operands (start) or on the running state
  always_comb begin
    op_rem = start ? '0 : rem_q;
    op_quo = start ? dividend : quo_q;
    op_dsr = start ? divisor : dsr_q;
    shl    = {op_rem, op_quo[W-1]};
    // partial remainder stays below the divisor, so W bits hold the difference
    diff   = shl[W-1:0] - op_dsr;

    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start || cnt_q != '0) begin
      if (shl >= {1'b0, op_dsr}) begin
        rem_d = diff;
        quo_d = {op_quo[W-2:0], 1'b1};
      end else begin
        rem_d = shl[W-1:0];
        quo_d = {op_quo[W-2:0], 1'b0};
      end
      dsr_d  = op_dsr;
      cnt_d  = start ? CW'(W - 1) : cnt_q - CW'(1);
      done_d = !start && (cnt_q == CW'(1));
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/pwm_param_rx.sv
// PWM parameter frame receiver: collects 5-word frames from the UDP stream,
// validates them and turns frequency/duty into clock-cycle counts using one
// shared serial divider, then issues a single-cycle config write.
module pwm_param_rx
  import pwm_param_rx_pkg::*;
#(
  parameter int PWM_NUM      = 5,
  parameter int ID_PWM_PARAM = 0,
  parameter int CLK_FREQ     = 100000000,
  parameter int DIV_W        = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rx_axis_udp_tdata,
  input  logic        rx_axis_udp_tvalid,
  input  logic        rx_axis_udp_tlast,
  input  logic [7:0]  rx_axis_udp_tuser,
  output logic        cfg_valid,
  output logic [7:0]  cfg_channel,
  output logic [31:0] cfg_period,
  output logic [31:0] cfg_high,
  output logic        cfg_en,
  output logic        err_frame,
  output logic        err_ovr,
  output logic        busy
);

  // collector
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  id_q, id_d, ch_q, ch_d;
  logic [31:0] freq_q, freq_d;
  logic [6:0]  duty_q, duty_d;
  logic        frame_end, id_match, frame_ok, accept;
  logic        err_frame_q, err_frame_d, err_ovr_q, err_ovr_d;

  // engine
  state_e      state_q, state_d;
  logic [7:0]  lch_q, lch_d;
  logic [6:0]  lduty_q, lduty_d;
  logic        len_q, len_d;
  logic [31:0] period_q, period_d;
  logic [38:0] product;

  // outputs
  logic        cfg_valid_q, cfg_valid_d, cfg_en_q, cfg_en_d;
  logic [7:0]  cfg_channel_q, cfg_channel_d;
  logic [31:0] cfg_period_q, cfg_period_d, cfg_high_q, cfg_high_d;

  // divider
  logic             div_start, div_done;
  logic [DIV_W-1:0] div_dividend, div_divisor, div_quo, div_rem_unused;
  logic [DIV_W-33:0] div_quo_hi_unused;

  assign busy              = (state_q != ST_IDLE);
  assign div_quo_hi_unused = div_quo[DIV_W-1:32];

  // Beat counting, word capture and the frame check on the tlast beat
  always_comb begin
    cnt_d  = cnt_q;
    id_d   = id_q;
    ch_d   = ch_q;
    freq_d = freq_q;
    duty_d = duty_q;
    if (rx_axis_udp_tvalid) begin
      case (cnt_q)
        3'(W_CH): begin
          ch_d = rx_axis_udp_tdata[7:0];
          id_d = rx_axis_udp_tuser;
        end
        3'(W_FREQ): freq_d = rx_axis_udp_tdata;
        3'(W_DUTY): duty_d = rx_axis_udp_tdata[6:0];
        3'(W_RSV):  ;  // reserved word is not interpreted
        default:    ;  // enable is taken straight off the tlast beat
      endcase
      if (rx_axis_udp_tlast)  cnt_d = '0;
      else if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
    end

    frame_end = rx_axis_udp_tvalid && rx_axis_udp_tlast;
    // a one-beat frame has its ID only on the live bus
    id_match  = ((cnt_q == 3'd0) ? rx_axis_udp_tuser : id_q) == 8'(ID_PWM_PARAM);
    frame_ok  = (cnt_q == 3'(FRAME_LEN - 1)) &&
                ({24'd0, ch_q} < 32'(PWM_NUM)) &&
                (freq_q != '0) && (freq_q <= 32'(CLK_FREQ / 2)) &&
                (duty_q <= 7'(DUTY_MAX));

    err_frame_d = frame_end && id_match && !frame_ok;
    err_ovr_d   = frame_end && id_match && frame_ok && busy;
    accept      = frame_end && id_match && frame_ok && !busy;
  end

  // Collector registers and error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      id_q        <= '0;
      ch_q        <= '0;
      freq_q      <= '0;
      duty_q      <= '0;
      err_frame_q <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      ch_q        <= ch_d;
      freq_q      <= freq_d;
      duty_q      <= duty_d;
      err_frame_q <= err_frame_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  // Calculation sequence: period divide, duty multiply, high-time divide, write out
  always_comb begin
    state_d       = state_q;
    lch_d         = lch_q;
    lduty_d       = lduty_q;
    len_d         = len_q;
    period_d      = period_q;
    cfg_valid_d   = 1'b0;
    cfg_channel_d = cfg_channel_q;
    cfg_period_d  = cfg_period_q;
    cfg_high_d    = cfg_high_q;
    cfg_en_d      = cfg_en_q;
    product       = 39'(period_q) * 39'(lduty_q);
    div_start     = 1'b0;
    div_dividend  = DIV_W'(CLK_FREQ);
    div_divisor   = DIV_W'(freq_q);
    unique case (state_q)
      ST_IDLE: if (accept) begin
        lch_d     = ch_q;
        lduty_d   = duty_q;
        len_d     = rx_axis_udp_tdata[0];
        div_start = 1'b1;
        state_d   = ST_DIV_P;
      end
      ST_DIV_P: if (div_done) begin
        period_d = div_quo[31:0];
        state_d  = ST_MUL;
      end
      ST_MUL: begin
        div_start    = 1'b1;
        div_dividend = DIV_W'(product);
        div_divisor  = DIV_W'(DUTY_MAX);
        state_d      = ST_DIV_H;
      end
      ST_DIV_H: if (div_done) state_d = ST_OUT;
      ST_OUT: begin
        cfg_valid_d   = 1'b1;
        cfg_channel_d = lch_q;
        cfg_period_d  = period_q;
        cfg_high_d    = div_quo[31:0];
        cfg_en_d      = len_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Engine state and registered config outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      lch_q         <= '0;
      lduty_q       <= '0;
      len_q         <= 1'b0;
      period_q      <= '0;
      cfg_valid_q   <= 1'b0;
      cfg_channel_q <= '0;
      cfg_period_q  <= '0;
      cfg_high_q    <= '0;
      cfg_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      lch_q         <= lch_d;
      lduty_q       <= lduty_d;
      len_q         <= len_d;
      period_q      <= period_d;
      cfg_valid_q   <= cfg_valid_d;
      cfg_channel_q <= cfg_channel_d;
      cfg_period_q  <= cfg_period_d;
      cfg_high_q    <= cfg_high_d;
      cfg_en_q      <= cfg_en_d;
    end
  end

  pwm_param_rx_div_serial #(.W(DIV_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem_unused)
  );

  assign cfg_valid   = cfg_valid_q;
  assign cfg_channel = cfg_channel_q;
  assign cfg_period  = cfg_period_q;
  assign cfg_high    = cfg_high_q;
  assign cfg_en      = cfg_en_q;
  assign err_frame   = err_frame_q;
  assign err_ovr     = err_ovr_q;

endmodule

// File: tb/tb_pwm_param_rx.sv
// Scoreboard bench for pwm_param_rx: the stimulus side feeds a frame-level
// reference model that queues expected config writes and error pulses with
// their cycle stamps; an independent monitor pops and compares.
module tb_pwm_param_rx;

  localparam int PWM_NUM  = 5;
  localparam int ID       = 0;
  localparam int CLK_FREQ = 100000000;
  localparam int DIV_W    = 40;
  localparam int LAT      = 2 * DIV_W + 3;

  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0;
  logic [7:0]  tuser = '0;
  logic        cfg_valid, cfg_en, err_frame, err_ovr, busy;
  logic [7:0]  cfg_channel;
  logic [31:0] cfg_period, cfg_high;

  pwm_param_rx #(.PWM_NUM(PWM_NUM), .ID_PWM_PARAM(ID), .CLK_FREQ(CLK_FREQ), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst),
    .rx_axis_udp_tdata(tdata), .rx_axis_udp_tvalid(tvalid),
    .rx_axis_udp_tlast(tlast), .rx_axis_udp_tuser(tuser),
    .cfg_valid(cfg_valid), .cfg_channel(cfg_channel), .cfg_period(cfg_period),
    .cfg_high(cfg_high), .cfg_en(cfg_en), .err_frame(err_frame), .err_ovr(err_ovr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [7:0]  ch;
    logic [31:0] per;
    logic [31:0] hi;
    logic        en;
  } exp_t;

  exp_t        exp_cfg[$];
  int          exp_ef[$];
  int          exp_eo[$];
  logic [31:0] fw[$];
  logic [7:0]  fid;
  int          busy_end = -1;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic evt_fail(input string name, input int at);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event at cycle %0d, observed at cycle %0d", name, at, cyc);
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    exp_cfg.delete();
    fw.delete();
    busy_end = -1;
  endtask

  task automatic model_beat(input logic [31:0] d, input logic last, input logic [7:0] id);
    logic   ok;
    longint per, hi;
    exp_t   e;
    if (fw.size() == 0) fid = id;
    fw.push_back(d);
    if (last) begin
      if (fid == 8'(ID)) begin
        ok = (fw.size() == 5) && (fw[0][7:0] < PWM_NUM) && (fw[1] != 0) &&
             (fw[1] <= CLK_FREQ / 2) && (fw[2][6:0] <= 100);
        if (!ok) exp_ef.push_back(cyc + 1);
        else if (cyc <= busy_end) exp_eo.push_back(cyc + 1);
        else begin
          per   = longint'(CLK_FREQ) / longint'(fw[1]);
          hi    = per * longint'(fw[2][6:0]) / 100;
          e.at  = cyc + LAT;
          e.ch  = fw[0][7:0];
          e.per = per[31:0];
          e.hi  = hi[31:0];
          e.en  = fw[4][0];
          exp_cfg.push_back(e);
          busy_end = cyc + LAT - 1;
        end
      end
      fw.delete();
    end
  endtask

  // ---------------- drivers ----------------
  task automatic beat(input logic [31:0] d, input logic last, input logic [7:0] id);
    @(negedge clk);
    tdata = d; tvalid = 1'b1; tlast = last; tuser = id;
    if (rst) model_beat(d, last, id);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tvalid = 1'b0; tlast = 1'b0; tdata = $urandom;
    end
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic [31:0] f, input logic [6:0] duty,
                            input logic en, input logic [7:0] id, input int nb, input bit bub);
    logic [31:0] w;
    for (int i = 0; i < nb; i++) begin
      case (i)
        0:       w = {24'd0, ch};
        1:       w = f;
        2:       w = {25'd0, duty};
        4:       w = {31'd0, en};
        default: w = $urandom;
      endcase
      if (bub && i > 0 && $urandom_range(0, 3) == 0) idle(1);
      beat(w, (i == nb - 1), id);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  int   mon_i;
  always @(negedge clk) begin
    if (rst) begin
      if (exp_cfg.size() > 0 && exp_cfg[0].at < cyc) begin
        mon_e = exp_cfg.pop_front();
        evt_fail("cfg_valid_missing", mon_e.at);
      end
      if (cfg_valid) begin
        if (exp_cfg.size() == 0) evt_fail("cfg_valid_unexpected", cyc);
        else begin
          mon_e = exp_cfg.pop_front();
          chk("cfg_latency_cycle", cyc, mon_e.at);
          chk("cfg_channel", cfg_channel, mon_e.ch);
          chk("cfg_period", cfg_period, mon_e.per);
          chk("cfg_high", cfg_high, mon_e.hi);
          chk("cfg_en", cfg_en, mon_e.en);
        end
      end
      if (exp_ef.size() > 0 && exp_ef[0] < cyc) begin
        mon_i = exp_ef.pop_front();
        evt_fail("err_frame_missing", mon_i);
      end
      if (err_frame) begin
        if (exp_ef.size() == 0) evt_fail("err_frame_unexpected", cyc);
        else begin
          mon_i = exp_ef.pop_front();
          chk("err_frame_cycle", cyc, mon_i);
        end
      end
      if (exp_eo.size() > 0 && exp_eo[0] < cyc) begin
        mon_i = exp_eo.pop_front();
        evt_fail("err_ovr_missing", mon_i);
      end
      if (err_ovr) begin
        if (exp_eo.size() == 0) evt_fail("err_ovr_unexpected", cyc);
        else begin
          mon_i = exp_eo.pop_front();
          chk("err_ovr_cycle", cyc, mon_i);
        end
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_cfg_valid"}, cfg_valid, 0);
    chk({tag, "_cfg_channel"}, cfg_channel, 0);
    chk({tag, "_cfg_period"}, cfg_period, 0);
    chk({tag, "_cfg_high"}, cfg_high, 0);
    chk({tag, "_cfg_en"}, cfg_en, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  ch, id;
    logic [31:0] f;
    logic [6:0]  duty;
    logic        en;
    int          r, nb;

    idle(3);
    chk_zero_outputs("reset");
    chk("reset_err_frame", err_frame, 0);
    chk("reset_err_ovr", err_ovr, 0);
    @(negedge clk); rst = 1'b1;
    idle(2);

    // main conversions
    send_frame(8'd2, 32'd100000, 7'd50, 1'b1, 8'd0, 5, 0); idle(90);
    send_frame(8'd1, 32'd55000, 7'd80, 1'b0, 8'd0, 5, 0);  idle(90);
    send_frame(8'd1, 32'd55000, 7'd100, 1'b0, 8'd0, 5, 0); idle(90);
    send_frame(8'd1, 32'd55000, 7'd20, 1'b1, 8'd0, 5, 0);  idle(90);
    send_frame(8'd1, 32'd55000, 7'd0, 1'b1, 8'd0, 5, 1);   idle(90);
    send_frame(8'd0, 32'd50000000, 7'd100, 1'b1, 8'd0, 5, 0); idle(90);
    send_frame(8'd4, 32'd1, 7'd99, 1'b1, 8'd0, 5, 0);      idle(90);

    // rejected frames
    send_frame(8'd5, 32'd1000, 7'd50, 1'b1, 8'd0, 5, 0);       idle(4);
    send_frame(8'd1, 32'd0, 7'd50, 1'b1, 8'd0, 5, 0);          idle(4);
    send_frame(8'd1, 32'd50000001, 7'd50, 1'b1, 8'd0, 5, 0);   idle(4);
    send_frame(8'd1, 32'd1000, 7'd101, 1'b1, 8'd0, 5, 0);      idle(4);
    send_frame(8'd1, 32'd1000, 7'd50, 1'b1, 8'd0, 4, 0);       idle(4);
    send_frame(8'd1, 32'd1000, 7'd50, 1'b1, 8'd0, 6, 0);       idle(4);
    send_frame(8'd1, 32'd1000, 7'd50, 1'b1, 8'd0, 9, 0);       idle(4);
    send_frame(8'd1, 32'd1000, 7'd50, 1'b1, 8'd3, 5, 0);       idle(10);

    // overrun: second tlast 20 cycles after the first, then a third once idle
    send_frame(8'd3, 32'd20000, 7'd25, 1'b1, 8'd0, 5, 0); idle(15);
    send_frame(8'd4, 32'd30000, 7'd75, 1'b0, 8'd0, 5, 0); idle(70);
    send_frame(8'd2, 32'd7, 7'd33, 1'b1, 8'd0, 5, 0);     idle(90);

    // reset while beat 2 is on the bus; the tail is a short frame
    beat({24'd0, 8'd3}, 1'b0, 8'd0);
    beat(32'd20000, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0; model_reset();
    tdata = 32'd40; tvalid = 1'b1; tlast = 1'b0;
    #1 chk_zero_outputs("rst_beat2");
    @(negedge clk); rst = 1'b1; tvalid = 1'b0;
    beat(32'd0, 1'b0, 8'd0);
    beat(32'd1, 1'b1, 8'd0);
    idle(6);
    send_frame(8'd1, 32'd123457, 7'd61, 1'b1, 8'd0, 5, 0); idle(90);

    // reset in the middle of the period divide
    send_frame(8'd0, 32'd3000, 7'd10, 1'b1, 8'd0, 5, 0); idle(20);
    @(negedge clk); rst = 1'b0; model_reset(); tvalid = 1'b0;
    #1 chk_zero_outputs("rst_divp");
    idle(2);
    @(negedge clk); rst = 1'b1;
    send_frame(8'd3, 32'd100000, 7'd50, 1'b0, 8'd0, 5, 0); idle(90);

    // randomized traffic with bubbles, bad frames and overlaps
    for (int k = 0; k < 40; k++) begin
      r    = $urandom_range(0, 9);
      ch   = 8'($urandom_range(0, PWM_NUM - 1));
      f    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, CLK_FREQ / 2)) : 32'($urandom_range(1, 5000));
      duty = 7'($urandom_range(0, 100));
      en   = 1'($urandom_range(0, 1));
      id   = 8'(ID);
      nb   = 5;
      if (r == 0) begin
        case ($urandom_range(0, 2))
          0:       ch = 8'($urandom_range(PWM_NUM, 255));
          1:       f = 32'($urandom_range(CLK_FREQ / 2 + 1, 32'hFFFFFFFF));
          default: duty = 7'($urandom_range(101, 127));
        endcase
      end else if (r == 1) id = 8'($urandom_range(1, 255));
      else if (r == 2) nb = $urandom_range(1, 8);
      send_frame(ch, f, duty, en, id, nb, 1);
      idle($urandom_range(0, 110));
    end

    // drain outstanding expectations (bounded)
    for (int i = 0; i < 400 && (exp_cfg.size() + exp_ef.size() + exp_eo.size()) > 0; i++) idle(1);
    chk("drain_cfg_pending", exp_cfg.size(), 0);
    chk("drain_err_frame_pending", exp_ef.size(), 0);
    chk("drain_err_ovr_pending", exp_eo.size(), 0);
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
